bus_send_arbiter: RTL and testbench
===================================

Name: bus_send_arbiter

Overview:
Shares the single bus send channel between NUM_REQ message requesters (e.g. per-core postoffice send ports). Each requester uses a valid/ready handshake carrying interface_send_data_t. A round-robin grant selects one request per cycle into a one-entry holding register. That register drives the bus val/ack send protocol. A stall monitor counts cycles the held message waits for bus_ack_i and raises an alarm past a limit.

Parameters:
NUM_REQ, 4, number of requesters (>=1)
STALL_LIMIT, 1024, stall_cycles_o value at or above which stall_alarm_o asserts (1..65535)
SRC_W (localparam), max(1,$clog2(NUM_REQ)), requester index width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, synchronous, active-high
req_valid_i  in  NUM_REQ  per-requester send valid
req_ready_o  out  NUM_REQ  per-requester accept (one-hot or zero)
req_data_i  in  NUM_REQ x $bits(interface_send_data_t)  per-requester message
bus_val_o  out  1  held message valid on bus
bus_ack_i  in  1  bus accepted held message this cycle
bus_dst_o  out  32  held message.meta.address
bus_tag_o  out  32  held message.meta.tag
bus_msg_o  out  64  held message.data
bus_src_id_o  out  SRC_W  index of requester owning held message
stall_cycles_o  out  16  consecutive cycles with bus_val_o=1 and bus_ack_i=0, saturating
stall_alarm_o  out  1  stall_cycles_o >= STALL_LIMIT

Behaviour:
- Reset (rst=1 at edge): hold_valid=0, hold_data=0, hold_src=0, rr_ptr=0, stall_cycles=0. bus_val_o=0, bus_dst/tag/msg=0, bus_src_id_o=0, stall_cycles_o=0, stall_alarm_o=0. req_ready_o is combinational and shows 0 only while inputs are idle. Reset mid-transfer drops the held message; no ack is owed.
- can_accept = !hold_valid | bus_ack_i. Same-cycle free-and-refill is allowed, giving back-to-back throughput of 1 msg/cycle.
- Grant: the first i with req_valid_i[i]=1, searching rr_ptr, rr_ptr+1, ... with wrap modulo NUM_REQ. req_ready_o[g] = can_accept. All other ready bits are 0.
- Ready is combinationally dependent on req_valid_i. Requesters must not make valid depend on ready.
- Accept (any valid & can_accept): next cycle hold_valid=1, hold_data=req_data_i[g], hold_src=g, rr_ptr=(g+1) mod NUM_REQ. Latency is 1 cycle from accept to bus_val_o.
- bus_ack_i with no accept: hold_valid<=0. bus_ack_i while hold_valid=0 is ignored and causes no state change.
- No accept and no ack: all state holds. rr_ptr changes only on accept.
- bus_val_o = hold_valid. Bus fields and bus_src_id_o are registered from hold_data/hold_src. They are stable while bus_val_o=1 and !bus_ack_i.
- Stall counter:
  - If hold_valid & !bus_ack_i: stall_cycles <= sat16(stall_cycles+1).
  - Otherwise (ack or idle): stall_cycles <= 0.
  - A refill on ack restarts at 0.
- stall_alarm_o is combinational from the stall_cycles register. It is observability only; there is no drop or retry.
- NUM_REQ=1: rr_ptr is constant 0 and the grant is a straight pass.

Decomposition:
- interface_send_data_t stays in xctcmsg_pkg. Add there: a bus_arb_src_t helper (SRC_W-wide index) and the STALL_CNT_W=16 constant.
- One natural sub-module: rr_arbiter. Inputs: req vector, ptr, enable. Outputs: one-hot grant and binary index. It is purely combinational, and rr_ptr stays in bus_send_arbiter.

Test Plan:
- Reset then idle: rst=1 for 2 cycles with req_valid_i=4'b1111 held -> bus_val_o=0, stall_cycles_o=0. First accept after rst drops is requester 0.
- Round-robin: req_valid_i=4'b1111 constantly, bus_ack_i=1 constantly -> bus_src_id_o sequence 0,1,2,3,0,... with bus_val_o=1 every cycle after the first. Each message's dst/tag/msg match its source (e.g. src 2 sends tag 0x22, data 0xDEAD_0002).
- Skip and wrap: rr_ptr=3, req_valid_i=4'b0101 -> grant 0, then 2, then 0. Requesters 1 and 3 are never readied.
- Backpressure: hold one message with bus_ack_i=0 for 5 cycles -> req_ready_o=0, bus fields stable, stall_cycles_o 1..5. Ack in cycle 6 with req 1 valid -> same-cycle accept, stall_cycles_o=0 next.
- Stall alarm and saturation: STALL_LIMIT=8, no ack -> stall_alarm_o rises when stall_cycles_o=8. Run 70000 cycles -> stall_cycles_o saturates at 65535.
- Spurious ack and mid-operation reset: bus_ack_i=1 with hold empty -> no change. Sync rst while bus_val_o=1 -> bus_val_o=0 next cycle and rr_ptr=0.

Source files
------------

// File: rtl/xctcmsg_pkg.sv
// Message types shared by the postoffice send path and the bus send arbiter.
package xctcmsg_pkg;

    typedef struct packed {
        logic [31:0] address;
        logic [31:0] tag;
    } interface_send_meta_t;

    typedef struct packed {
        interface_send_meta_t meta;
        logic [63:0]          data;
    } interface_send_data_t;

    localparam int STALL_CNT_W = 16;

    function automatic int bus_arb_src_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int BUS_ARB_NUM_REQ = 4;
    localparam int BUS_ARB_SRC_W   = bus_arb_src_w(BUS_ARB_NUM_REQ);

    typedef logic [BUS_ARB_SRC_W-1:0] bus_arb_src_t;

endpackage

// File: rtl/bus_send_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int SRC_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [SRC_W-1:0]   ptr,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [SRC_W-1:0]   grant_idx
);

    logic             hi_found;
    logic             lo_found;
    logic [SRC_W-1:0] hi_idx;
    logic [SRC_W-1:0] lo_idx;

    // Descending scan so the lowest qualifying index is the one left standing.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[i] && (i >= int'(ptr))) begin
                hi_found = 1'b1;
                hi_idx   = SRC_W'(i);
            end
            if (req[i]) begin
                lo_found = 1'b1;
                lo_idx   = SRC_W'(i);
            end
        end
        grant_idx = hi_found ? hi_idx : lo_idx;
        grant     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant[i] = enable && lo_found && (SRC_W'(i) == grant_idx);
        end
    end

endmodule

// File: rtl/bus_send_arbiter.sv
// Round-robin share of the bus send channel with a one-entry holding register
// and a saturating stall monitor on the bus ack.
module bus_send_arbiter
    import xctcmsg_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int STALL_LIMIT = 1024,
    localparam int SRC_W      = bus_arb_src_w(NUM_REQ)
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_REQ-1:0]                  req_valid_i,
    output logic [NUM_REQ-1:0]                  req_ready_o,
    input  interface_send_data_t [NUM_REQ-1:0]  req_data_i,
    output logic                                bus_val_o,
    input  logic                                bus_ack_i,
    output logic [31:0]                         bus_dst_o,
    output logic [31:0]                         bus_tag_o,
    output logic [63:0]                         bus_msg_o,
    output logic [SRC_W-1:0]                    bus_src_id_o,
    output logic [STALL_CNT_W-1:0]              stall_cycles_o,
    output logic                                stall_alarm_o
);

    logic                   hold_valid;
    interface_send_data_t   hold_data;
    logic [SRC_W-1:0]       hold_src;
    logic [SRC_W-1:0]       rr_ptr;
    logic [STALL_CNT_W-1:0] stall_cycles;

    logic                   can_accept;
    logic                   accept;
    logic [NUM_REQ-1:0]     grant;
    logic [SRC_W-1:0]       grant_idx;
    logic [SRC_W-1:0]       ptr_next;

    // An ack frees the slot in the same cycle, so a refill can ride on it.
    assign can_accept = !hold_valid || bus_ack_i;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .SRC_W   (SRC_W)
    ) u_rr_arbiter (
        .req       (req_valid_i),
        .ptr       (rr_ptr),
        .enable    (can_accept),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign req_ready_o = grant;
    assign accept      = |grant;
    assign ptr_next    = (grant_idx == SRC_W'(NUM_REQ - 1)) ? '0 : grant_idx + SRC_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_valid   <= 1'b0;
            hold_data    <= '0;
            hold_src     <= '0;
            rr_ptr       <= '0;
            stall_cycles <= '0;
        end else begin
            if (accept) begin
                hold_valid <= 1'b1;
                hold_data  <= req_data_i[grant_idx];
                hold_src   <= grant_idx;
                rr_ptr     <= ptr_next;
            end else if (bus_ack_i && hold_valid) begin
                hold_valid <= 1'b0;
            end

            if (hold_valid && !bus_ack_i) begin
                if (stall_cycles != '1) begin
                    stall_cycles <= stall_cycles + STALL_CNT_W'(1);
                end
            end else begin
                stall_cycles <= '0;
            end
        end
    end

    assign bus_val_o      = hold_valid;
    assign bus_dst_o      = hold_data.meta.address;
    assign bus_tag_o      = hold_data.meta.tag;
    assign bus_msg_o      = hold_data.data;
    assign bus_src_id_o   = hold_src;
    assign stall_cycles_o = stall_cycles;
    assign stall_alarm_o  = (stall_cycles >= STALL_CNT_W'(STALL_LIMIT));

endmodule

// File: tb/tb_bus_send_arbiter.sv
// Bench for bus_send_arbiter: directed scenarios plus random traffic, all
// checked every cycle against a queue-free behavioural model of the channel.
module tb_bus_send_arbiter;
    import xctcmsg_pkg::*;

    localparam int N     = 4;
    localparam int LIMIT = 8;

    logic                          clk = 1'b0;
    logic                          rst;
    logic [N-1:0]                  req_valid;
    logic [N-1:0]                  req_ready;
    interface_send_data_t [N-1:0]  req_data;
    logic                          bus_val;
    logic                          bus_ack;
    logic [31:0]                   bus_dst;
    logic [31:0]                   bus_tag;
    logic [63:0]                   bus_msg;
    logic [1:0]                    bus_src_id;
    logic [15:0]                   stall_cycles;
    logic                          stall_alarm;

    int total = 0;
    int bad   = 0;

    // model state
    bit                   m_known = 0;
    bit                   m_hv;
    interface_send_data_t m_data;
    int                   m_src;
    int                   m_ptr;
    int                   m_stall;

    bus_send_arbiter #(
        .NUM_REQ     (N),
        .STALL_LIMIT (LIMIT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_data_i     (req_data),
        .bus_val_o      (bus_val),
        .bus_ack_i      (bus_ack),
        .bus_dst_o      (bus_dst),
        .bus_tag_o      (bus_tag),
        .bus_msg_o      (bus_msg),
        .bus_src_id_o   (bus_src_id),
        .stall_cycles_o (stall_cycles),
        .stall_alarm_o  (stall_alarm)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int m_grant(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic check_model();
        int g;
        bit can;
        logic [N-1:0] exp_ready;
        if (!m_known) return;
        g = m_grant(req_valid);
        can = !m_hv || bus_ack;
        exp_ready = (g >= 0 && can) ? N'(1 << g) : '0;
        chk("m_ready", 64'(req_ready), 64'(exp_ready));
        chk("m_val", 64'(bus_val), 64'(m_hv));
        if (m_hv) begin
            chk("m_dst", 64'(bus_dst), 64'(m_data.meta.address));
            chk("m_tag", 64'(bus_tag), 64'(m_data.meta.tag));
            chk("m_msg", bus_msg, m_data.data);
            chk("m_src", 64'(bus_src_id), 64'(m_src));
        end
        chk("m_stall", 64'(stall_cycles), 64'(m_stall));
        chk("m_alarm", 64'(stall_alarm), 64'(m_stall >= LIMIT));
    endtask

    task automatic model_update();
        int g;
        bit can;
        if (rst) begin
            m_known = 1;
            m_hv    = 0;
            m_data  = '0;
            m_src   = 0;
            m_ptr   = 0;
            m_stall = 0;
            return;
        end
        g   = m_grant(req_valid);
        can = !m_hv || bus_ack;
        m_stall = (m_hv && !bus_ack) ? ((m_stall < 65535) ? m_stall + 1 : 65535) : 0;
        if (can && g >= 0) begin
            m_hv   = 1;
            m_data = req_data[g];
            m_src  = g;
            m_ptr  = (g + 1) % N;
        end else if (bus_ack) begin
            m_hv = 0;
        end
    endtask

    task automatic cycle();
        @(negedge clk);
        check_model();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic set_data();
        for (int i = 0; i < N; i++) begin
            req_data[i].meta.address = 32'h1000_0000 + 32'(i);
            req_data[i].meta.tag     = 32'h11 * 32'(i);
            req_data[i].data         = 64'hDEAD_0000 + 64'(i);
        end
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 4'hF;
        bus_ack = 1'b0;
        set_data();

        // reset with all requesters asking
        cycle();
        cycle();
        chk("rst_val", 64'(bus_val), 64'd0);
        chk("rst_stall", 64'(stall_cycles), 64'd0);

        // round-robin with continuous ack
        rst = 1'b0;
        bus_ack = 1'b1;
        #1;
        chk("first_ready", 64'(req_ready), 64'b0001);
        for (int j = 0; j < 8; j++) begin
            cycle();
            chk("rr_val", 64'(bus_val), 64'd1);
            chk("rr_src", 64'(bus_src_id), 64'(j % 4));
            if (j == 2) begin
                chk("rr_tag2", 64'(bus_tag), 64'h22);
                chk("rr_msg2", bus_msg, 64'hDEAD_0002);
                chk("rr_dst2", 64'(bus_dst), 64'h1000_0002);
            end
        end

        // skip and wrap from pointer 3
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        repeat (3) cycle();
        req_valid = 4'b0101;
        #1;
        chk("skip_ready0", 64'(req_ready), 64'b0001);
        cycle();
        chk("skip_src0", 64'(bus_src_id), 64'd0);
        chk("skip_ready2", 64'(req_ready), 64'b0100);
        cycle();
        chk("skip_src2", 64'(bus_src_id), 64'd2);
        chk("skip_ready0b", 64'(req_ready), 64'b0001);
        cycle();
        chk("skip_src0b", 64'(bus_src_id), 64'd0);

        // backpressure on the held message
        req_valid = 4'b0010;
        bus_ack = 1'b0;
        for (int s = 1; s <= 5; s++) begin
            cycle();
            chk("bp_stall", 64'(stall_cycles), 64'(s));
            chk("bp_ready", 64'(req_ready), 64'd0);
            chk("bp_dst", 64'(bus_dst), 64'h1000_0000);
        end
        bus_ack = 1'b1;
        #1;
        chk("bp_refill_ready", 64'(req_ready), 64'b0010);
        cycle();
        chk("bp_stall0", 64'(stall_cycles), 64'd0);
        chk("bp_src1", 64'(bus_src_id), 64'd1);

        // spurious acks on an empty hold
        req_valid = 4'b0000;
        cycle();
        for (int s = 0; s < 3; s++) begin
            cycle();
            chk("spur_val", 64'(bus_val), 64'd0);
            chk("spur_stall", 64'(stall_cycles), 64'd0);
        end

        // reset while a message is held
        req_valid = 4'b0100;
        bus_ack = 1'b0;
        cycle();
        cycle();
        chk("mid_val1", 64'(bus_val), 64'd1);
        rst = 1'b1;
        req_valid = 4'hF;
        cycle();
        chk("mid_val0", 64'(bus_val), 64'd0);
        rst = 1'b0;
        bus_ack = 1'b1;
        cycle();
        chk("mid_src0", 64'(bus_src_id), 64'd0);

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            rst       = ($urandom_range(0, 63) == 0);
            req_valid = 4'($urandom);
            bus_ack   = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++)
                req_data[i] = {$urandom, $urandom, $urandom, $urandom};
            cycle();
        end

        // alarm threshold and saturation
        rst = 1'b1;
        bus_ack = 1'b0;
        set_data();
        cycle();
        rst = 1'b0;
        req_valid = 4'b0001;
        cycle();
        req_valid = 4'b0000;
        repeat (7) cycle();
        chk("alarm_stall7", 64'(stall_cycles), 64'd7);
        chk("alarm_off7", 64'(stall_alarm), 64'd0);
        cycle();
        chk("alarm_stall8", 64'(stall_cycles), 64'd8);
        chk("alarm_on8", 64'(stall_alarm), 64'd1);
        repeat (70000) cycle();
        chk("sat_stall", 64'(stall_cycles), 64'd65535);
        chk("sat_alarm", 64'(stall_alarm), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
